// File: rtl/mash_dec_pkg.sv
// Shared constants, accumulator-width helper and warm-up FSM states for
// the MASH CIC decimator.
package mash_dec_pkg;

  localparam int IN_W      = 4;   // signed MASH sample width (-3..+4)
  localparam int OUT_W     = 16;  // unsigned reconstructed sample width
  localparam int CIC_ORDER = 3;   // integrator/comb stage count

  // Bit growth of an order-3 CIC is 3*log2(R) over the input width.
  function automatic int acc_width(input int log2r, input int in_w = IN_W);
    return in_w + CIC_ORDER * log2r;
  endfunction

  // First two output-stage events only flush the comb delay elements.
  typedef enum logic [1:0] {
    WARM0 = 2'd0,
    WARM1 = 2'd1,
    RUN   = 2'd2
  } warm_state_e;

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC differentiator: y = x - x_prev, modular, advancing
// only when the decimated event is at this stage.
module cic_comb_stage #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);

  logic [W-1:0] prev_q;
  logic [W-1:0] y_q;

  // Delay element and difference register both move only on the event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      y_q    <= '0;
    end else if (en_i) begin
      prev_q <= x_i;
      y_q    <= x_i - prev_q;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/mash_cic_decimator.sv
// Third-order CIC decimator reconstructing a 16-bit unsigned sample from a
// MASH sigma-delta bitstream. Build option: define MASH_DEC_ROUND_EN for
// round-half-up before the output shift (default is truncation).
module mash_cic_decimator
  import mash_dec_pkg::*;
#(
  parameter int LOG2R = 6,
  parameter int IN_W  = mash_dec_pkg::IN_W,
  parameter int OUT_W = mash_dec_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid
);

  localparam int ACC_W = acc_width(LOG2R, IN_W);
  localparam int SHIFT = CIC_ORDER * LOG2R - OUT_W;

  // ---------------------------------------------------------------- integrators
  logic [CIC_ORDER-1:0][ACC_W-1:0] integ_q, integ_d;
  logic [ACC_W-1:0]                din_ext;
  logic [LOG2R-1:0]                cnt_q;
  logic                            dec_ev;

  assign din_ext = {{(ACC_W-IN_W){din[IN_W-1]}}, din};
  assign dec_ev  = din_valid && (cnt_q == '1);

  // Cascade uses each stage's new value so the event sample reaches stage 3.
  always_comb begin
    integ_d[0] = integ_q[0] + din_ext;
    for (int k = 1; k < CIC_ORDER; k++)
      integ_d[k] = integ_q[k] + integ_d[k-1];
  end

  // Integrators and decimation counter advance only on accepted samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ_q <= '0;
      cnt_q   <= '0;
    end else if (din_valid) begin
      integ_q <= integ_d;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------- comb chain
  logic [CIC_ORDER:0]              vld_pipe_q;
  logic [CIC_ORDER:0][ACC_W-1:0]   comb_x;

  // Event token walks alongside the data: one slot per comb plus output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe_q <= '0;
    else     vld_pipe_q <= {vld_pipe_q[CIC_ORDER-1:0], dec_ev};
  end

  assign comb_x[0] = integ_q[CIC_ORDER-1];

  for (genvar k = 0; k < CIC_ORDER; k++) begin : g_comb
    cic_comb_stage #(.W(ACC_W)) u_comb (
      .clk  (clk),
      .rst  (rst),
      .en_i (vld_pipe_q[k]),
      .x_i  (comb_x[k]),
      .y_o  (comb_x[k+1])
    );
  end

  // ---------------------------------------------------------------- scaling
  logic signed [ACC_W:0] pre_shift;
  logic signed [ACC_W:0] shifted;
  logic [OUT_W-1:0]      sat;

`ifdef MASH_DEC_ROUND_EN
  localparam logic signed [ACC_W:0] RND_K = (ACC_W+1)'(1) << (SHIFT-1);
`else
  localparam logic signed [ACC_W:0] RND_K = '0;
`endif

  // Extra headroom bit keeps the rounding add from wrapping before the clamp.
  always_comb begin
    pre_shift = signed'({comb_x[CIC_ORDER][ACC_W-1], comb_x[CIC_ORDER]}) + RND_K;
    shifted   = pre_shift >>> SHIFT;
    sat       = shifted[OUT_W-1:0];
    if (shifted[ACC_W])               sat = '0;
    else if (|shifted[ACC_W-1:OUT_W]) sat = '1;
  end

  // ---------------------------------------------------------------- warm-up FSM
  warm_state_e      state_q, state_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  // Next state / output: suppress the first two events while combs settle.
  always_comb begin
    state_d      = state_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (vld_pipe_q[CIC_ORDER]) begin
      unique case (state_q)
        WARM0:   state_d = WARM1;
        WARM1:   state_d = RUN;
        RUN: begin
          dout_d       = sat;
          dout_valid_d = 1'b1;
        end
        default: state_d = WARM0;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WARM0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: doc/mash_cic_decimator.md
# mash_cic_decimator

Receive-side companion to the MASH sigma-delta modulator. Accepts the modulator's short signed output stream at the oversampled rate and reconstructs a 16-bit unsigned sample with a third-order CIC decimation filter (decimation ratio 2^LOG2R). Sits in loopback/verification paths and in any ADC-style return path that consumes a MASH bitstream. Output scaling undoes the CIC gain, so a modulator input x1 returns as dout ≈ x1 after settling.

## Interface
- LOG2R, 6, log2 of decimation ratio R; legal range 6..10 (requires 3*LOG2R ≥ 16)
- IN_W, 4, width of signed MASH sample (covers -3..+4)
- OUT_W, 16, output sample width
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  sole clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- din_valid  in  1  din is sampled on this edge
- din  in  IN_W  signed two's-complement modulator output
- dout  out  OUT_W  reconstructed unsigned sample, held between strobes
- dout_valid  out  1  one-cycle strobe, dout new this cycle

## Operation
- ACC_W = IN_W + 3*LOG2R; SHIFT = 3*LOG2R - OUT_W.
- Three cascaded integrators, ACC_W bits each, update only on din_valid; wrap modulo 2^ACC_W (intended, never saturate).
- Decimation counter 0..R-1 advances on din_valid; wraps to 0 after R-1.
- Decimation event: din_valid with counter == R-1; integrator-3 value including this sample enters the comb pipeline.
- Three comb stages (y = x - x_prev, ACC_W bits, modular), each stage registered, each stage's delay element updates only when the event passes that stage.
- Output stage: comb result >>> SHIFT (arithmetic), then clamp: negative → 0x0000, > 0xFFFF → 0xFFFF.
- Warm-up FSM: WARM0 → WARM1 → RUN, advancing on each output-stage event; events in WARM0/WARM1 update comb state but do not assert dout_valid or change dout. In RUN every event asserts dout_valid.
- Reset values: all integrators, combs, counter = 0; FSM = WARM0; dout = 0x0000; dout_valid = 0.
- Reset mid-operation: pipeline contents discarded, no strobe emitted, warm-up restarts.
- din_valid gaps: state frozen; decimation counts accepted samples, not clocks.

## Timing
- Latency: dout_valid asserts exactly 4 rising edges after the edge accepting the R-th sample (3 comb registers + output register).
- Throughput: one input per clock; at most one dout_valid per R accepted samples; strobes never back-to-back for R ≥ 64.
- First dout_valid after reset: on the 3rd decimation event (first fully-settled output; impulse length 3R-2).
- dout stable from strobe until next strobe.

## Configuration
- MASH_DEC_ROUND_EN defined: add 2^(SHIFT-1) before the shift (round half up), then clamp.
- Undefined: plain truncation toward −∞. Clamp identical in both builds.

## Structure
- Package mash_dec_pkg: IN_W, OUT_W, CIC order constant (3), acc_width(log2r) function, warm-up FSM state enum.
- Sub-module cic_comb_stage (registered differentiator with enable and delay element), instantiated three times.

## Test plan
- Reset then din=0 continuous, R=64 → first dout_valid on edge 4 after sample 192, dout=0x0000; strobes every 64 samples.
- Repeating din pattern 1,0,0,0 → settled dout=0x4000 exactly, both builds.
- Repeating +4,-3 → dout=0x8000; din=+1 constant → dout=0xFFFF (clamp high); din=-1 constant → 0x0000 (clamp low).
- din_valid toggled every other clock with pattern 1,0,0,0 → same values, strobe spacing 128 clocks.
- One 1 in each 64-sample window (mean 1/64, SHIFT=2, comb result 2^12) then add one 1 per 3 windows → truncation vs MASH_DEC_ROUND_EN differ by 1 LSB where residue ≥ 2.
- Assert rst mid-window after 2 outputs → dout=0, dout_valid=0 immediately; next strobe only after 3 further decimation events.
